pio_pattern_sequencer: RTL and testbench

PIO_PATTERN_SEQUENCER -- requirements
Module: pio_pattern_sequencer

---
 rtl/pio_seq_pkg.sv | 43 ++++
 rtl/pio_pattern_sequencer_if.sv | 22 ++
 rtl/pio_seq_step_timer.sv | 28 ++
 rtl/pio_pattern_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_pio_pattern_sequencer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pio_seq_pkg.sv
// Shared definitions for the PIO pattern sequencer: register map, field
// positions, FSM encoding and small helpers for the effective PERIOD/LENGTH.
package pio_seq_pkg;

  localparam int PERIOD_W = 24;
  localparam int LENGTH_W = 5;
  localparam int STEP_W   = 4;

  localparam logic [3:0] ADDR_CONTROL = 4'd0;
  localparam logic [3:0] ADDR_PERIOD  = 4'd1;
  localparam logic [3:0] ADDR_STATUS  = 4'd2;
  localparam logic [3:0] ADDR_LENGTH  = 4'd3;
  localparam logic [3:0] ADDR_PATTERN = 4'd8;

  localparam int CTRL_RUN_BIT    = 0;
  localparam int CTRL_LOOP_BIT   = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  localparam int STAT_BUSY_BIT = 0;
  localparam int STAT_DONE_BIT = 1;
  localparam int STAT_STEP_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_HOLD  = 2'd2
  } seq_state_e;

  // A zero period would never reach terminal count, so it runs as 1.
  function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] period);
    return (period == '0) ? PERIOD_W'(1) : period;
  endfunction

  function automatic logic [LENGTH_W-1:0] eff_length(input logic [LENGTH_W-1:0] len,
                                                     input logic [LENGTH_W-1:0] max_len);
    if (len == '0)
      return LENGTH_W'(1);
    if (len > max_len)
      return max_len;
    return len;
  endfunction

endpackage

// File: rtl/pio_pattern_sequencer_if.sv
// Bus bundles for the sequencer: the zero-wait-state config slave and the
// write-only PIO master port.
interface pio_seq_cfg_if;
  logic [3:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

interface pio_seq_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;

  modport master (output address, chipselect, write_n, writedata);
  modport slave  (input address, chipselect, write_n, writedata);
endinterface

// File: rtl/pio_seq_step_timer.sv
// Loadable down-counter timing one pattern step; tc flags the last count
// so the FSM can advance on the same cycle.
module pio_seq_step_timer
  import pio_seq_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic                en,
  input  logic [PERIOD_W-1:0] load_value,
  output logic                tc
);

  logic [PERIOD_W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - PERIOD_W'(1);
    end
  end

  assign tc = en && (count_reg == PERIOD_W'(1));

endmodule

// File: rtl/pio_pattern_sequencer.sv
// Plays a table of DATA_W-bit patterns out to a PIO peripheral, one master
// write per step, PERIOD+1 cycles apart, with optional looping and a done irq.
module pio_pattern_sequencer
  import pio_seq_pkg::*;
#(
  parameter int NUM_STEPS = 8,
  parameter int DATA_W    = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  pio_seq_cfg_if.slave  s,
  pio_seq_pio_if.master m,
  output logic          irq
);

  localparam int                  IDX_W   = $clog2(NUM_STEPS);
  localparam logic [LENGTH_W-1:0] MAX_LEN = LENGTH_W'(NUM_STEPS);

  seq_state_e          state_reg, state_next;
  logic [STEP_W-1:0]   step_reg, step_next;
  logic                run_reg, loop_reg, irq_en_reg, done_reg;
  logic [PERIOD_W-1:0] period_reg;
  logic [LENGTH_W-1:0] length_reg;
  logic [DATA_W-1:0]   pattern_reg [NUM_STEPS];

  logic                wr_en, ctrl_wr, busy, start, abort, finish;
  logic                timer_load, timer_tc;
  logic [3:0]          pat_off;
  logic                pat_hit;
  logic [IDX_W-1:0]    pat_idx;
  logic [IDX_W-1:0]    step_idx;
  logic [LENGTH_W-1:0] step_inc, len_eff;
  logic                m_cs, m_wn;
  logic [31:0]         m_wd, rd_data;

  assign wr_en    = s.chipselect && !s.write_n;
  assign ctrl_wr  = wr_en && (s.address == ADDR_CONTROL);
  assign busy     = (state_reg != ST_IDLE);
  assign start    = ctrl_wr && s.writedata[CTRL_RUN_BIT] && !busy;
  assign abort    = ctrl_wr && !s.writedata[CTRL_RUN_BIT] && busy;

  assign pat_off  = s.address - ADDR_PATTERN;
  assign pat_hit  = (s.address >= ADDR_PATTERN) && ({1'b0, pat_off} < MAX_LEN);
  assign pat_idx  = pat_off[IDX_W-1:0];
  assign step_idx = step_reg[IDX_W-1:0];

  assign step_inc = {1'b0, step_reg} + LENGTH_W'(1);
  assign len_eff  = eff_length(length_reg, MAX_LEN);

  pio_seq_step_timer u_step_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (timer_load),
    .en         (state_reg == ST_HOLD),
    .load_value (eff_period(period_reg)),
    .tc         (timer_tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      step_reg  <= '0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    timer_load = 1'b0;
    finish     = 1'b0;
    m_cs       = 1'b0;
    m_wn       = 1'b1;
    m_wd       = '0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_WRITE;
          step_next  = '0;
        end
      end
      ST_WRITE: begin
        m_cs       = 1'b1;
        m_wn       = 1'b0;
        m_wd       = 32'(pattern_reg[step_idx]);
        timer_load = 1'b1;
        state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (timer_tc) begin
          if (step_inc == len_eff) begin
            if (loop_reg) begin
              step_next  = '0;
              state_next = ST_WRITE;
            end else begin
              step_next  = step_inc[STEP_W-1:0];
              finish     = 1'b1;
              state_next = ST_IDLE;
            end
          end else begin
            step_next  = step_inc[STEP_W-1:0];
            state_next = ST_WRITE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // An abort overrides any completion landing in the same cycle, so done is untouched.
    if (abort) begin
      state_next = ST_IDLE;
      finish     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_reg    <= 1'b0;
      loop_reg   <= 1'b0;
      irq_en_reg <= 1'b0;
      done_reg   <= 1'b0;
      period_reg <= PERIOD_W'(1);
      length_reg <= MAX_LEN;
    end else begin
      if (ctrl_wr) begin
        loop_reg   <= s.writedata[CTRL_LOOP_BIT];
        irq_en_reg <= s.writedata[CTRL_IRQ_EN_BIT];
      end
      if (finish || abort) begin
        run_reg <= 1'b0;
      end else if (start) begin
        run_reg <= 1'b1;
      end
      // Completion beats a same-cycle W1C so the event is never lost.
      if (finish) begin
        done_reg <= 1'b1;
      end else if (wr_en && (s.address == ADDR_STATUS) && s.writedata[STAT_DONE_BIT]) begin
        done_reg <= 1'b0;
      end
      if (wr_en && (s.address == ADDR_PERIOD)) begin
        period_reg <= s.writedata[PERIOD_W-1:0];
      end
      if (wr_en && (s.address == ADDR_LENGTH)) begin
        length_reg <= s.writedata[LENGTH_W-1:0];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_STEPS; gi++) begin : g_pattern
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          pattern_reg[gi] <= '0;
        end else if (wr_en && pat_hit && (pat_idx == IDX_W'(gi))) begin
          pattern_reg[gi] <= s.writedata[DATA_W-1:0];
        end
      end
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    case (s.address)
      ADDR_CONTROL: begin
        rd_data[CTRL_RUN_BIT]    = run_reg;
        rd_data[CTRL_LOOP_BIT]   = loop_reg;
        rd_data[CTRL_IRQ_EN_BIT] = irq_en_reg;
      end
      ADDR_PERIOD: rd_data[PERIOD_W-1:0] = period_reg;
      ADDR_STATUS: begin
        rd_data[STAT_BUSY_BIT]               = busy;
        rd_data[STAT_DONE_BIT]               = done_reg;
        rd_data[STAT_STEP_LSB +: STEP_W]     = step_reg;
      end
      ADDR_LENGTH: rd_data[LENGTH_W-1:0] = length_reg;
      default: begin
        if (pat_hit) begin
          rd_data[DATA_W-1:0] = pattern_reg[pat_idx];
        end
      end
    endcase
  end

  assign s.readdata   = rd_data;
  assign m.address    = 2'd0;
  assign m.chipselect = m_cs;
  assign m.write_n    = m_wn;
  assign m.writedata  = m_wd;
  assign irq          = done_reg & irq_en_reg;

endmodule

// File: tb/tb_pio_pattern_sequencer.sv
// Directed bench: register accesses drive the sequencer, expected PIO writes
// are queued with their spacing and checked by an independent monitor.
module tb_pio_pattern_sequencer;
  import pio_seq_pkg::*;

  localparam int NUM_STEPS = 8;
  localparam int DATA_W    = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic irq;

  pio_seq_cfg_if cfg_bus ();
  pio_seq_pio_if pio_bus ();

  pio_pattern_sequencer #(.NUM_STEPS(NUM_STEPS), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s       (cfg_bus),
    .m       (pio_bus),
    .irq     (irq)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          gap;   // required cycles since the previous write, 0 = unchecked
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_wr_cyc = 0;
  int   wr_seen = 0;

  always @(posedge clk) cyc++;

  // Monitor: every master strobe is matched against the head of the queue.
  always @(negedge clk) begin
    if (pio_bus.chipselect && !pio_bus.write_n) begin
      wr_seen++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL pio_write: got unexpected write data %h, required no write", pio_bus.writedata);
      end else begin
        mon_e = exp_q.pop_front();
        if (pio_bus.writedata !== mon_e.data || pio_bus.address !== 2'd0) begin
          n_err++;
          $display("FAIL pio_write #%0d: got addr %0d data %h, required addr 0 data %h",
                   wr_seen, pio_bus.address, pio_bus.writedata, mon_e.data);
        end else begin
          $display("pio_write #%0d: data %h at cycle %0d ok", wr_seen, pio_bus.writedata, cyc);
        end
        if (mon_e.gap != 0) begin
          n_vec++;
          if (cyc - last_wr_cyc != mon_e.gap) begin
            n_err++;
            $display("FAIL pio_gap #%0d: got %0d cycles, required %0d", wr_seen, cyc - last_wr_cyc, mon_e.gap);
          end
        end
      end
      last_wr_cyc = cyc;
    end else if (pio_bus.chipselect || !pio_bus.write_n || pio_bus.writedata != 32'd0) begin
      n_vec++;
      n_err++;
      $display("FAIL pio_idle: got cs %0b wn %0b data %h, required 0 1 0",
               pio_bus.chipselect, pio_bus.write_n, pio_bus.writedata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else begin
      $display("check %s: %h ok", name, act);
    end
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [31:0] req, input string name);
    cfg_bus.address = a;
    #1;
    chk(name, cfg_bus.readdata, req);
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_bus.address    = a;
    cfg_bus.writedata  = d;
    cfg_bus.chipselect = 1'b1;
    cfg_bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    cfg_bus.chipselect = 1'b0;
    cfg_bus.write_n    = 1'b1;
    $display("cfg_write addr %0d data %h", a, d);
  endtask

  task automatic push_exp(input logic [31:0] d, input int gap);
    exp_t e;
    e.data = d;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      cfg_bus.address = ADDR_STATUS;
      #1;
      if (!cfg_bus.readdata[STAT_BUSY_BIT]) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got busy after %0d cycles, required idle", name, max_cyc);
    end
  endtask

  task automatic wait_writes(input int target, input int max_cyc, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(posedge clk);
      if (wr_seen >= target) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got %0d writes, required %0d", name, wr_seen, target);
    end
  endtask

  initial begin
    int base;
    logic [31:0] pv;
    cfg_bus.address    = '0;
    cfg_bus.chipselect = 1'b0;
    cfg_bus.write_n    = 1'b1;
    cfg_bus.writedata  = '0;

    // Reset values, observed while reset is held.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_cs", 32'(pio_bus.chipselect), 32'd0);
    chk("rst_m_wn", 32'(pio_bus.write_n), 32'd1);
    chk("rst_m_wd", pio_bus.writedata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rd_chk(ADDR_PERIOD, 32'd1, "rst_period");
    rd_chk(ADDR_LENGTH, 32'd8, "rst_length");
    reset_n = 1'b1;
    rd_chk(ADDR_CONTROL, 32'd0, "rst_control");
    rd_chk(ADDR_STATUS, 32'd0, "rst_status");
    rd_chk(4'd8, 32'd0, "rst_pattern0");

    // Unmapped addresses read 0 and ignore writes.
    cfg_write(4'd5, 32'hDEAD_BEEF);
    rd_chk(4'd5, 32'd0, "unmapped5");
    rd_chk(4'd4, 32'd0, "unmapped4");

    // Single pass of four steps, PERIOD=3 -> writes 4 cycles apart.
    cfg_write(4'd8, 32'd1);
    cfg_write(4'd9, 32'd2);
    cfg_write(4'd10, 32'd4);
    cfg_write(4'd11, 32'd8);
    cfg_write(ADDR_LENGTH, 32'd4);
    cfg_write(ADDR_PERIOD, 32'd3);
    push_exp(32'd1, 0);
    push_exp(32'd2, 4);
    push_exp(32'd4, 4);
    push_exp(32'd8, 4);
    cfg_write(ADDR_CONTROL, 32'h1);
    wait_idle(100, "pass_idle");
    repeat (10) @(posedge clk);
    #1;
    rd_chk(ADDR_STATUS, 32'h42, "pass_status");
    chk("pass_irq_off", 32'(irq), 32'd0);
    rd_chk(ADDR_CONTROL, 32'd0, "pass_run_clr");
    chk("pass_q_empty", 32'(exp_q.size()), 32'd0);
    rd_chk(4'd10, 32'd4, "pattern2_rd");
    cfg_write(4'd12, 32'hFF);
    rd_chk(4'd12, 32'hF, "pattern_mask");
    cfg_write(ADDR_STATUS, 32'h2);
    rd_chk(ADDR_STATUS, 32'h40, "done_w1c");

    // Loop mode A,B,A then abort before the 4th write.
    cfg_write(4'd8, 32'h5);
    cfg_write(4'd9, 32'hA);
    cfg_write(ADDR_LENGTH, 32'd2);
    cfg_write(ADDR_PERIOD, 32'd2);
    push_exp(32'h5, 0);
    push_exp(32'hA, 3);
    push_exp(32'h5, 3);
    base = wr_seen;
    cfg_write(ADDR_CONTROL, 32'h3);
    wait_writes(base + 3, 100, "loop_writes");
    cfg_write(ADDR_CONTROL, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    rd_chk(ADDR_STATUS, 32'h00, "abort_status");
    chk("abort_count", 32'(wr_seen - base), 32'd3);

    // PERIOD=0, LENGTH=0: one write, done two cycles after the start.
    cfg_write(ADDR_PERIOD, 32'd0);
    cfg_write(ADDR_LENGTH, 32'd0);
    cfg_write(4'd8, 32'h7);
    push_exp(32'h7, 0);
    cfg_write(ADDR_CONTROL, 32'h1);
    rd_chk(ADDR_STATUS, 32'h01, "min_write_busy");
    @(posedge clk);
    #1;
    rd_chk(ADDR_STATUS, 32'h01, "min_hold_busy");
    @(posedge clk);
    #1;
    rd_chk(ADDR_STATUS, 32'h12, "min_done");
    cfg_write(ADDR_STATUS, 32'h2);

    // LENGTH above the table depth clamps to NUM_STEPS, interval PERIOD_eff+1 = 2.
    cfg_write(ADDR_LENGTH, 32'd20);
    for (int i = 0; i < NUM_STEPS; i++) begin
      pv = 32'((3 * i + 1) & 15);
      cfg_write(4'(8 + i), pv);
      push_exp(pv, (i == 0) ? 0 : 2);
    end
    cfg_write(ADDR_CONTROL, 32'h1);
    wait_idle(200, "clamp_idle");
    rd_chk(ADDR_STATUS, 32'h82, "clamp_status");
    rd_chk(ADDR_LENGTH, 32'd20, "clamp_length_rd");
    chk("clamp_q_empty", 32'(exp_q.size()), 32'd0);
    cfg_write(ADDR_STATUS, 32'h2);

    // Interrupt, with a W1C landing exactly on the completion edge.
    cfg_write(4'd8, 32'h1);
    cfg_write(ADDR_LENGTH, 32'd1);
    cfg_write(ADDR_PERIOD, 32'd2);
    push_exp(32'h1, 0);
    cfg_write(ADDR_CONTROL, 32'h5);
    repeat (2) @(posedge clk);
    #1;
    cfg_write(ADDR_STATUS, 32'h2);
    rd_chk(ADDR_STATUS, 32'h12, "irq_setwins");
    chk("irq_high", 32'(irq), 32'd1);
    cfg_write(ADDR_STATUS, 32'h2);
    rd_chk(ADDR_STATUS, 32'h10, "irq_w1c_status");
    chk("irq_low", 32'(irq), 32'd0);
    rd_chk(ADDR_CONTROL, 32'h4, "irq_en_kept");

    // Reset in the middle of HOLD.
    cfg_write(ADDR_LENGTH, 32'd4);
    cfg_write(ADDR_PERIOD, 32'd5);
    push_exp(32'h1, 0);
    cfg_write(ADDR_CONTROL, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_m_cs", 32'(pio_bus.chipselect), 32'd0);
    chk("mid_rst_m_wn", 32'(pio_bus.write_n), 32'd1);
    rd_chk(ADDR_PERIOD, 32'd1, "mid_rst_period");
    rd_chk(ADDR_LENGTH, 32'd8, "mid_rst_length");
    rd_chk(ADDR_STATUS, 32'd0, "mid_rst_status");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    base = wr_seen;
    repeat (40) @(posedge clk);
    #1;
    chk("post_rst_writes", 32'(wr_seen - base), 32'd0);
    rd_chk(ADDR_STATUS, 32'd0, "post_rst_idle");
    chk("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
